// File: rtl/data_sram_resp_pkg.sv
// rtl/data_sram_resp_pkg.sv - shared constants and byte-lane merge helper for the data SRAM responder
package data_sram_resp_pkg;

    // Deepest supported read-return pipeline.
    localparam int RD_LAT_MAX = 4;

    // Value returned for a read whose address falls outside the array.
    localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

    // Lanes with we[i]=1 take the new byte; all other lanes keep the old byte.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  we
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_array.sv
// rtl/data_sram_array.sv - word storage with byte-enabled synchronous write and registered read
//
// Ports:
//   clk    clock
//   wr_en  commit a write to addr this edge (already range-qualified)
//   we     byte lane enables for the write
//   rd_en  capture mem[addr] into rdata this edge
//   addr   word index
//   wdata  lane-aligned write data
//   rdata  registered read word (not reset; qualified by the caller's valid bit)
module data_sram_array
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [3:0]        we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= byte_merge(mem[addr], wdata, we);
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder: range decode, read-latency pipeline, sticky error flag
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   data_sram_en       request valid this cycle
//   data_sram_we       byte write enables, 0 = read
//   data_sram_addr     byte address (bits [1:0] ignored)
//   data_sram_wdata    lane-aligned write data
//   data_sram_rdata    read data, holds its value between returns
//   data_sram_rvalid   one-cycle pulse RD_LAT edges after a read request
//   addr_err           sticky out-of-range flag, cleared only by reset
//   rd_cnt, wr_cnt, err_cnt  request counters, present only with DATA_SRAM_STATS_EN
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          ADDR_W = 14,
    parameter logic [31:0] BASE   = 32'h1C00_0000,
    parameter int          RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        addr_err
`ifdef DATA_SRAM_STATS_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
    output logic [31:0] err_cnt
`endif
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("data_sram_resp: RD_LAT must be within 1..4");
    end

    logic [31:0]       offset;
    logic              in_range;
    logic              rd_req;
    logic              wr_req;
    logic [31:0]       arr_rdata;
    logic              rd_oor;
    logic [RD_LAT-1:0] vld;
    logic [31:0]       s1_data;
    logic [31:0]       last_data;
    logic [31:0]       rdata_q;

    // Any offset bit at or above ADDR_W+2 means the address lies past the
    // array (or below BASE, which wraps to a huge unsigned offset).
    assign offset   = data_sram_addr - BASE;
    assign in_range = (offset >> (ADDR_W + 2)) == 32'd0;
    assign rd_req   = data_sram_en && (data_sram_we == 4'b0000);
    assign wr_req   = data_sram_en && (data_sram_we != 4'b0000);

    // The array's read register is pipeline stage 1.
    data_sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .wr_en (wr_req && in_range),
        .we    (data_sram_we),
        .rd_en (rd_req),
        .addr  (offset[ADDR_W+1:2]),
        .wdata (data_sram_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_oor <= 1'b0;
            vld    <= '0;
        end else begin
            if (rd_req) begin
                rd_oor <= !in_range;
            end
            vld[0] <= rd_req;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    assign s1_data = rd_oor ? OOR_RDATA : arr_rdata;

    if (RD_LAT == 1) begin : g_lat1
        assign last_data = s1_data;
    end else begin : g_latn
        logic [31:0] dq [RD_LAT-1];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    dq[i] <= '0;
                end
            end else begin
                dq[0] <= s1_data;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    dq[i] <= dq[i-1];
                end
            end
        end

        assign last_data = dq[RD_LAT-2];
    end

    // rdata shows the returning word during the rvalid cycle and otherwise
    // repeats whatever was last shown.
    assign data_sram_rvalid = vld[RD_LAT-1];
    assign data_sram_rdata  = data_sram_rvalid ? last_data : rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q  <= '0;
            addr_err <= 1'b0;
        end else begin
            rdata_q <= data_sram_rdata;
            if (data_sram_en && !in_range) begin
                addr_err <= 1'b1;
            end
        end
    end

`ifdef DATA_SRAM_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (rd_req) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_req && in_range) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (data_sram_en && !in_range) begin
                err_cnt <= err_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - bench for data_sram_resp at RD_LAT 1, 3 and 4 against a behavioural model
module tb_data_sram_resp;

    localparam int          ADDR_W = 14;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h1C00_0000;
    localparam int          NI     = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        en     = 1'b0;
    logic [3:0]  we     = 4'h0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;

    logic        rv [NI];
    logic [31:0] rd [NI];
    logic        ae [NI];
`ifdef DATA_SRAM_STATS_EN
    logic [31:0] rc [NI];
    logic [31:0] wc [NI];
    logic [31:0] ec [NI];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_sram_resp #(
            .ADDR_W (ADDR_W),
            .BASE   (BASE),
            .RD_LAT ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk              (clk),
            .resetn           (resetn),
            .data_sram_en     (en),
            .data_sram_we     (we),
            .data_sram_addr   (addr),
            .data_sram_wdata  (wdata),
            .data_sram_rdata  (rd[g]),
            .data_sram_rvalid (rv[g]),
            .addr_err         (ae[g])
`ifdef DATA_SRAM_STATS_EN
            ,
            .rd_cnt           (rc[g]),
            .wr_cnt           (wc[g]),
            .err_cnt          (ec[g])
`endif
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Behavioural model: a word array, a per-edge log of read results, and
    // the edge number of the most recent reset. A read logged at edge s is
    // visible on an instance of latency L right after edge s+L-1.
    logic [31:0] mem_m [DEPTH];
    int          edge_n   = 0;
    int          rst_edge = -1000;
    bit          hist_v [int];
    logic [31:0] hist_d [int];
    logic [31:0] held [NI] = '{32'h0, 32'h0, 32'h0};
    bit          err_m = 1'b0;
    logic [31:0] rc_m = 0, wc_m = 0, ec_m = 0;

    always @(posedge clk) begin
        logic [31:0] off;
        bit          inr;
        edge_n++;
        if (!resetn) begin
            rst_edge = edge_n;
            err_m    = 1'b0;
            for (int k = 0; k < NI; k++) held[k] = 32'h0;
            rc_m = 0; wc_m = 0; ec_m = 0;
        end else if (en) begin
            off = addr - BASE;
            inr = off < 32'(4 * DEPTH);
            if (!inr) begin
                err_m = 1'b1;
                ec_m++;
            end
            if (we == 4'h0) begin
                hist_v[edge_n] = 1'b1;
                hist_d[edge_n] = inr ? mem_m[off / 4] : 32'h0;
                rc_m++;
            end else if (inr) begin
                wc_m++;
                for (int i = 0; i < 4; i++)
                    if (we[i]) mem_m[off / 4][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int src;
            bit v;
            src = edge_n - lat_of(k) + 1;
            v   = (src > rst_edge) && hist_v.exists(src);
            if (v) held[k] = hist_d[src];
            chk($sformatf("rvalid_lat%0d", lat_of(k)), {31'b0, rv[k]}, {31'b0, v});
            chk($sformatf("rdata_lat%0d", lat_of(k)), rd[k], held[k]);
            chk($sformatf("addr_err_lat%0d", lat_of(k)), {31'b0, ae[k]}, {31'b0, err_m});
`ifdef DATA_SRAM_STATS_EN
            chk($sformatf("rd_cnt_lat%0d", lat_of(k)), rc[k], rc_m);
            chk($sformatf("wr_cnt_lat%0d", lat_of(k)), wc[k], wc_m);
            chk($sformatf("err_cnt_lat%0d", lat_of(k)), ec[k], ec_m);
`endif
        end
    end

    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 4'($urandom), $urandom, $urandom);
    endtask

    task automatic wr(input int word, input logic [31:0] d, input logic [3:0] w);
        cyc(1'b1, w, BASE + 32'(word * 4), d);
    endtask

    task automatic rdw(input int word);
        cyc(1'b1, 4'h0, BASE + 32'(word * 4), $urandom);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 39);
        if (r < 32) return BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
        if (r < 36) return BASE + 32'((DEPTH - 4 + r - 32) * 4) + 32'($urandom_range(0, 3));
        if (r == 36) return BASE - 32'($urandom_range(1, 64));
        if (r == 37) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        if (r == 38) return 32'h0;
        return 32'hFFFF_FFFC;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    logic        obs_v [7];
    logic [31:0] obs_d [7];
    int          cnt;

    initial begin
        resetn = 1'b0;
        idle(2);
        for (int k = 0; k < NI; k++) begin
            chk("reset_rvalid", {31'b0, rv[k]}, 32'h0);
            chk("reset_rdata", rd[k], 32'h0);
            chk("reset_addr_err", {31'b0, ae[k]}, 32'h0);
        end
        resetn = 1'b1;
        idle(1);

        for (int w = 0; w < 32; w++) wr(w, $urandom, 4'hF);
        for (int w = DEPTH - 4; w < DEPTH; w++) wr(w, $urandom, 4'hF);

        // Write then read on the very next cycle.
        wr(4, 32'h1234_5678, 4'hF);
        rdw(4);
        chk("raw_rvalid", {31'b0, rv[0]}, 32'h1);
        chk("raw_rdata", rd[0], 32'h1234_5678);
        idle(1);
        chk("raw_rvalid_pulse", {31'b0, rv[0]}, 32'h0);
        chk("raw_rdata_hold", rd[0], 32'h1234_5678);

        // Byte-lane merging.
        wr(8, 32'hAABB_CCDD, 4'hF);
        wr(8, 32'h0000_EE00, 4'b0010);
        rdw(8);
        chk("merge_lane1", rd[0], 32'hAABB_EEDD);
        wr(8, 32'h9900_0000, 4'b1000);
        rdw(8);
        chk("merge_lane3", rd[0], 32'h99BB_EEDD);

        // Back-to-back reads on the RD_LAT=3 instance.
        wr(0, 32'd1, 4'hF);
        wr(1, 32'd2, 4'hF);
        wr(2, 32'd3, 4'hF);
        idle(4);
        for (int i = 0; i < 7; i++) begin
            if (i < 3) rdw(i); else idle(1);
            obs_v[i] = rv[1];
            obs_d[i] = rd[1];
        end
        for (int i = 0; i < 7; i++)
            chk($sformatf("pipe3_rvalid_%0d", i), {31'b0, obs_v[i]}, {31'b0, (i >= 2 && i <= 4)});
        chk("pipe3_rdata_0", obs_d[2], 32'd1);
        chk("pipe3_rdata_1", obs_d[3], 32'd2);
        chk("pipe3_rdata_2", obs_d[4], 32'd3);

        // Out-of-range read and write.
        cyc(1'b1, 4'h0, BASE - 32'd4, 32'h0);
        chk("oor_rd_rvalid", {31'b0, rv[0]}, 32'h1);
        chk("oor_rd_rdata", rd[0], 32'h0);
        chk("oor_rd_addr_err", {31'b0, ae[0]}, 32'h1);
        idle(3);
        cyc(1'b1, 4'hF, BASE + 32'(4 * DEPTH), 32'hDEAD_BEEF);
        rdw(0);
        chk("oor_wr_word0", rd[0], 32'd1);
        chk("oor_wr_addr_err", {31'b0, ae[0]}, 32'h1);
        idle(4);

        // Reset while a read is in flight on the RD_LAT=4 instance.
        rdw(1);
        idle(1);
        resetn = 1'b0;
        #1;
        chk("midrst_rvalid", {31'b0, rv[2]}, 32'h0);
        chk("midrst_rdata", rd[2], 32'h0);
        chk("midrst_addr_err", {31'b0, ae[2]}, 32'h0);
        idle(2);
        resetn = 1'b1;
        cnt = 0;
        repeat (8) begin
            idle(1);
            if (rv[2]) cnt++;
        end
        chk("midrst_no_rvalid", 32'(cnt), 32'h0);

        // Randomised traffic.
        repeat (500) begin
            if ($urandom_range(0, 9) < 3) begin
                idle(1);
            end else if ($urandom_range(0, 1) == 0) begin
                cyc(1'b1, 4'h0, rand_addr(), $urandom);
            end else begin
                cyc(1'b1, 4'($urandom_range(1, 15)), rand_addr(), $urandom);
            end
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
